// File: rtl/formula_1_pipe_param.sv
// Pipelined three-root formula block.
// Takes isqrt of a, b and c, then combines the roots according to mode
// (sum, sa+sb*sc, or product). The result saturates to all-ones on overflow.
// Latency is ISQRT_STAGES+2 cycles and one argument set is accepted per clock.

// Pipelined integer square root, restoring digit-by-digit method.
// The n/2 result bits are spread evenly over n_pipe_stages register stages,
// so the latency is exactly n_pipe_stages cycles.
module isqrt #(
    parameter int n             = 32,
    parameter int n_pipe_stages = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_vld,
    input  logic [n-1:0]     x,
    output logic             y_vld,
    output logic [n/2-1:0]   y
);
    localparam int HN  = n / 2;
    localparam int RW  = HN + 2;
    localparam int IPS = (HN + n_pipe_stages - 1) / n_pipe_stages;

    for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
        localparam int IT_LO = s * IPS;
        localparam int IT_HI = ((s + 1) * IPS < HN) ? (s + 1) * IPS : HN;

        logic [n-1:0]  x_in, x_nx;
        logic [HN-1:0] root_in, root_nx;
        logic [RW-1:0] rem_in, rem_nx, trial;
        logic          vld_in;
        logic [HN-1:0] root_q;
        logic          vld_q;

        if (s == 0) begin : g_src
            assign x_in    = x;
            assign root_in = '0;
            assign rem_in  = '0;
            assign vld_in  = x_vld;
        end else begin : g_src
            assign x_in    = g_stage[s-1].g_carry.x_q;
            assign root_in = g_stage[s-1].root_q;
            assign rem_in  = g_stage[s-1].g_carry.rem_q;
            assign vld_in  = g_stage[s-1].vld_q;
        end

        // This stage's share of root bits: two radicand bits consumed per bit.
        always_comb begin
            x_nx    = x_in;
            root_nx = root_in;
            rem_nx  = rem_in;
            trial   = '0;
            for (int k = IT_LO; k < IT_HI; k++) begin
                rem_nx = {rem_nx[RW-3:0], x_nx[n-1:n-2]};
                trial  = {root_nx, 2'b01};
                if (rem_nx >= trial) begin
                    rem_nx  = rem_nx - trial;
                    root_nx = {root_nx[HN-2:0], 1'b1};
                end else begin
                    root_nx = {root_nx[HN-2:0], 1'b0};
                end
                x_nx = {x_nx[n-3:0], 2'b00};
            end
        end

        // Valid always shifts; data only loads behind a valid input.
        always_ff @(posedge clk) begin
            if (rst) vld_q <= 1'b0;
            else     vld_q <= vld_in;
            if (vld_in) root_q <= root_nx;
        end

        // Remainder and remaining radicand are only needed by a following stage.
        if (s < n_pipe_stages - 1) begin : g_carry
            logic [n-1:0]  x_q;
            logic [RW-1:0] rem_q;

            // Carry the partial state forward alongside the root.
            always_ff @(posedge clk) begin
                if (vld_in) begin
                    x_q   <= x_nx;
                    rem_q <= rem_nx;
                end
            end
        end
    end

    assign y     = g_stage[n_pipe_stages-1].root_q;
    assign y_vld = g_stage[n_pipe_stages-1].vld_q;
endmodule

module formula_1_pipe_param #(
    parameter int W            = 32,
    parameter int ISQRT_STAGES = 4,
    parameter int TAG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [1:0]       mode,
    input  logic [TAG_W-1:0] tag,
    output logic             res_vld,
    output logic [W-1:0]     res,
    output logic             res_ovf,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);
    localparam int HW = W / 2;
    localparam int WW = W + HW;

    logic          ya_vld, yb_vld, yc_vld;
    logic [HW-1:0] ya, yb, yc;

    isqrt #(.n(W), .n_pipe_stages(ISQRT_STAGES)) u_isqrt_a (
        .clk(clk), .rst(rst), .x_vld(arg_vld), .x(a), .y_vld(ya_vld), .y(ya)
    );
    isqrt #(.n(W), .n_pipe_stages(ISQRT_STAGES)) u_isqrt_b (
        .clk(clk), .rst(rst), .x_vld(arg_vld), .x(b), .y_vld(yb_vld), .y(yb)
    );
    isqrt #(.n(W), .n_pipe_stages(ISQRT_STAGES)) u_isqrt_c (
        .clk(clk), .rst(rst), .x_vld(arg_vld), .x(c), .y_vld(yc_vld), .y(yc)
    );

    // Side-band line carrying mode and tag in step with the roots.
    logic [ISQRT_STAGES-1:0] sh_vld_q;
    logic [1:0]              sh_mode_q [ISQRT_STAGES];
    logic [TAG_W-1:0]        sh_tag_q  [ISQRT_STAGES];

    // Side-band valid bits shift every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_vld_q <= '0;
        end else begin
            sh_vld_q[0] <= arg_vld;
            for (int k = 1; k < ISQRT_STAGES; k++) sh_vld_q[k] <= sh_vld_q[k-1];
        end
    end

    // Side-band data moves only behind a valid bit, so idle inputs never toggle it.
    always_ff @(posedge clk) begin
        if (arg_vld) begin
            sh_mode_q[0] <= mode;
            sh_tag_q[0]  <= tag;
        end
        for (int k = 1; k < ISQRT_STAGES; k++) begin
            if (sh_vld_q[k-1]) begin
                sh_mode_q[k] <= sh_mode_q[k-1];
                sh_tag_q[k]  <= sh_tag_q[k-1];
            end
        end
    end

    logic             s1_vld_q;
    logic [HW-1:0]    sa_q, sb_q, sc_q;
    logic [W-1:0]     p1_q;
    logic [1:0]       s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Stage 1: hold the roots and form sb*sc, which cannot exceed W bits.
    always_ff @(posedge clk) begin
        if (rst) s1_vld_q <= 1'b0;
        else     s1_vld_q <= ya_vld;
        if (ya_vld) begin
            sa_q      <= ya;
            sb_q      <= yb;
            sc_q      <= yc;
            p1_q      <= {{HW{1'b0}}, yb} * {{HW{1'b0}}, yc};
            s1_mode_q <= sh_mode_q[ISQRT_STAGES-1];
            s1_tag_q  <= sh_tag_q[ISQRT_STAGES-1];
        end
    end

    logic [WW-1:0] wide_d;
    logic [W-1:0]  res_d;
    logic          res_ovf_d;

    // Stage 2 next state: wide result, then saturate into W bits.
    always_comb begin
        wide_d    = '0;
        res_d     = '0;
        res_ovf_d = 1'b0;
        case (s1_mode_q)
            2'd0:    wide_d = {{W{1'b0}}, sa_q} + {{W{1'b0}}, sb_q} + {{W{1'b0}}, sc_q};
            2'd1:    wide_d = {{W{1'b0}}, sa_q} + {{HW{1'b0}}, p1_q};
            2'd2:    wide_d = {{W{1'b0}}, sa_q} * {{HW{1'b0}}, p1_q};
            default: wide_d = '0;
        endcase
        if (s1_mode_q == 2'd3) begin
            res_d     = '0;
            res_ovf_d = 1'b1;
        end else if (wide_d[WW-1:W] != '0) begin
            res_d     = '1;
            res_ovf_d = 1'b1;
        end else begin
            res_d     = wide_d[W-1:0];
            res_ovf_d = 1'b0;
        end
    end

    logic             res_vld_q;
    logic [W-1:0]     res_q;
    logic             res_ovf_q;
    logic [TAG_W-1:0] res_tag_q;

    // Output registers: pulse valid, hold data between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld_q <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            res_tag_q <= '0;
        end else begin
            res_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                res_q     <= res_d;
                res_ovf_q <= res_ovf_d;
                res_tag_q <= s1_tag_q;
            end
        end
    end

    assign res_vld = res_vld_q;
    assign res     = res_q;
    assign res_ovf = res_ovf_q;
    assign res_tag = res_tag_q;

    // The b/c root valids duplicate the side-band line's last bit; folding
    // them in keeps busy honest even if the root chains ever disagree.
    assign busy = (|sh_vld_q) | s1_vld_q | yb_vld | yc_vld;
endmodule
